// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM command decoder
package pwm_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_RX, ST_CHECK, ST_STROBE, ST_DRAIN} state_e;
    typedef enum logic [1:0] {ERR_LEN = 2'd0, ERR_CHANNEL = 2'd1, ERR_TIMEOUT = 2'd2, ERR_ABORT = 2'd3} err_code_e;
    localparam int PWM_PAYLOAD_BYTES = 5;
endpackage

// File: rtl/pwm_cmd_decoder.sv
// pwm_cmd_decoder: validates a 5-byte "set PWM" payload and issues one config write to the PWM bank
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_start, cmd_len       frame start pulse and payload length (sampled on start)
//   cmd_data/_valid/_ready   payload byte stream, transfer = valid & ready
//   cmd_done                 end-of-frame pulse from the dispatcher
//   config_*                 channel/period/duty for the bank, written on config_update_strobe
//   busy                     high outside IDLE
//   err_pulse, err_code      one-cycle error pulse; code holds until the next error
module pwm_cmd_decoder
    import pwm_pkg::*;
#(
    parameter int NUM_CHANNELS   = 8,
    parameter int COUNTER_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_start,
    input  logic [15:0]              cmd_len,
    input  logic [7:0]               cmd_data,
    input  logic                     cmd_data_valid,
    output logic                     cmd_data_ready,
    input  logic                     cmd_done,
    output logic [2:0]               config_ch_index_out,
    output logic [COUNTER_WIDTH-1:0] config_period_out,
    output logic [COUNTER_WIDTH-1:0] config_duty_out,
    output logic                     config_update_strobe,
    output logic                     busy,
    output logic                     err_pulse,
    output logic [1:0]               err_code
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = 8 + 2 * COUNTER_WIDTH;

    state_e                   state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [SW-1:0]            sh_q, sh_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [2:0]               ch_q, ch_d;
    logic [COUNTER_WIDTH-1:0] period_q, period_d, duty_q, duty_d;
    logic                     strobe_q, strobe_d, err_q, err_d;
    err_code_e                code_q, code_d;
    logic                     xfer, tmo_hit;
    logic [7:0]               rx_ch;
    logic [COUNTER_WIDTH-1:0] rx_period, rx_duty;

    assign cmd_data_ready       = (state_q == ST_RX) || (state_q == ST_DRAIN);
    assign xfer                 = cmd_data_valid && cmd_data_ready;
    assign tmo_hit              = !xfer && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign rx_ch                = sh_q[SW-1 -: 8];
    assign rx_period            = sh_q[2*COUNTER_WIDTH-1 -: COUNTER_WIDTH];
    assign rx_duty              = sh_q[COUNTER_WIDTH-1:0];
    assign busy                 = state_q != ST_IDLE;
    assign config_ch_index_out  = ch_q;
    assign config_period_out    = period_q;
    assign config_duty_out      = duty_q;
    assign config_update_strobe = strobe_q;
    assign err_pulse            = err_q;
    assign err_code             = code_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        tmo_d    = '0;
        ch_d     = ch_q;
        period_d = period_q;
        duty_d   = duty_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        if (xfer && state_q == ST_RX) begin
            sh_d  = {sh_q[SW-9:0], cmd_data};
            cnt_d = cnt_q + 3'd1;
        end
        // idle-cycle counter; any accepted byte restarts it
        if (cmd_data_ready && !xfer)
            tmo_d = tmo_q + 1'b1;
        case (state_q)
            ST_RX: begin
                if (xfer && cnt_q == 3'(PWM_PAYLOAD_BYTES - 1)) begin
                    state_d = ST_CHECK;
                end else if (cmd_done) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_LEN;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (cmd_done) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (int'(rx_ch) >= NUM_CHANNELS) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_CHANNEL;
                end else begin
                    state_d  = ST_STROBE;
                    strobe_d = 1'b1;
                    ch_d     = rx_ch[2:0];
                    period_d = rx_period;
                    duty_d   = (rx_duty > rx_period) ? rx_period : rx_duty;
                end
            end
            ST_STROBE: state_d = ST_IDLE;
            default: ;
        endcase
        // a new frame pre-empts whatever was in flight, including a pending config write
        if (cmd_start) begin
            if (state_q != ST_IDLE) begin
                err_d  = 1'b1;
                code_d = ERR_ABORT;
            end
            strobe_d = 1'b0;
            ch_d     = ch_q;
            period_d = period_q;
            duty_d   = duty_q;
            cnt_d    = '0;
            tmo_d    = '0;
            if (cmd_len == 16'(PWM_PAYLOAD_BYTES)) begin
                state_d = ST_RX;
            end else begin
                state_d = ST_DRAIN;
                err_d   = 1'b1;
                code_d  = ERR_LEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            tmo_q    <= '0;
            ch_q     <= '0;
            period_q <= '0;
            duty_q   <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_LEN;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            tmo_q    <= tmo_d;
            ch_q     <= ch_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end
endmodule
